// File: rtl/wishbone_plic_gen2_pkg.sv
// Shared address map, region and trigger types for the PLIC.
// Decode uses word-address bits [19:0] only.
package plic_gen2_pkg;

    localparam int DATA_W = 32;

    localparam logic [19:0] PRIO_BASE = 20'h00000;
    localparam logic [19:0] PEND_BASE = 20'h00400;
    localparam logic [19:0] EN_BASE   = 20'h00800;
    localparam logic [19:0] THR_BASE  = 20'h80000;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_PRIO,
        RGN_PEND,
        RGN_EN,
        RGN_THR,
        RGN_CLAIM
    } region_e;

    typedef enum logic {
        TRIG_LEVEL,
        TRIG_EDGE
    } trig_e;

    typedef struct packed {
        region_e    rgn;
        logic [8:0] ctx;
        logic [9:0] idx;
    } decode_t;

    function automatic decode_t decode(input logic [19:0] a);
        decode_t d;
        d.rgn = RGN_NONE;
        d.ctx = '0;
        d.idx = '0;
        unique case (1'b1)
            a[19] == THR_BASE[19]: begin
                d.ctx = a[18:10];
                if (a[9:0] == 10'd0)
                    d.rgn = RGN_THR;
                else if (a[9:0] == 10'd1)
                    d.rgn = RGN_CLAIM;
            end
            a[19:10] == PRIO_BASE[19:10]: begin
                d.rgn = RGN_PRIO;
                d.idx = a[9:0];
            end
            a[19:5] == PEND_BASE[19:5]: begin
                d.rgn = RGN_PEND;
                d.idx = {5'd0, a[4:0]};
            end
            a[19:11] == EN_BASE[19:11]: begin
                d.rgn = RGN_EN;
                d.ctx = {3'd0, a[10:5]};
                d.idx = {5'd0, a[4:0]};
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wishbone_plic_gen2_if.sv
// Wishbone classic slave bundle for the PLIC.
// Master drives cycle/strobe/address/data, slave returns data and ack.
interface wishbone_plic_gen2_if
    import plic_gen2_pkg::*;
#(
    parameter int PADDR_SIZE = 30
);
    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_we;
    logic [PADDR_SIZE-1:0] wb_adr;
    logic [DATA_W-1:0]     wb_dat_i;
    logic [DATA_W-1:0]     wb_dat_o;
    logic                  wb_ack;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack
    );
endinterface

// File: rtl/wishbone_plic_gen2_gateway.sv
// Per-source gateway: pending, in-flight, deferred edge and edge history.
// A claim always beats a gateway set in the same cycle.
module plic_gateway
    import plic_gen2_pkg::*;
#(
    parameter trig_e MODE = TRIG_LEVEL
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    input  logic claim,
    input  logic complete,
    output logic pending
);
    logic inflight;
    logic deferred;
    logic prev;
    logic rise;
    logic idle;
    logic set;

    assign rise = line & ~prev;
    assign idle = ~pending & ~inflight;

    always_comb begin
        set = 1'b0;
        if (MODE == TRIG_EDGE)
            set = idle & (rise | deferred);
        else
            set = idle & line;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending  <= 1'b0;
            inflight <= 1'b0;
            deferred <= 1'b0;
            prev     <= 1'b0;
        end else begin
            prev <= line;
            if (claim)
                pending <= 1'b0;
            else if (set)
                pending <= 1'b1;
            if (complete)
                inflight <= 1'b0;
            else if (claim)
                inflight <= 1'b1;
            // one-deep memory of an edge seen while busy
            if (MODE == TRIG_EDGE) begin
                if (set)
                    deferred <= 1'b0;
                else if (rise && !idle)
                    deferred <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/wishbone_plic_gen2.sv
// Wishbone PLIC: register file, per-target arbitration, claim/complete.
// Arbitration and target outputs are each one register stage deep.
module wishbone_plic_gen2
    import plic_gen2_pkg::*;
#(
    parameter int                 SOURCES    = 32,
    parameter int                 TARGETS    = 2,
    parameter int                 PRIO_BITS  = 3,
    parameter logic [SOURCES-1:0] EDGE_MASK  = '0,
    parameter int                 PADDR_SIZE = 30,
    parameter int                 PDATA_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    wishbone_plic_gen2_if.slave wb,
    input  logic [SOURCES-1:0]  sources,
    output logic [TARGETS-1:0]  targets
);
    localparam int NW  = (SOURCES + 31) / 32;
    localparam int KW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int IDW = $clog2(SOURCES);
    localparam int TW  = (TARGETS > 1) ? $clog2(TARGETS) : 1;

    logic                  req;
    logic                  rd;
    logic                  wr;
    decode_t               d;
    logic                  id_ok;
    logic                  k_ok;
    logic                  t_ok;
    logic [IDW-1:0]        id;
    logic [KW-1:0]         k;
    logic [TW-1:0]         t;
    logic [PDATA_SIZE-1:0] rdata;
    logic                  unused_adr;

    logic                  ack_q;
    logic [PDATA_SIZE-1:0] dat_q;
    logic                  claim_q;

    logic [PRIO_BITS-1:0]  prio_q [SOURCES];
    logic [31:0]           en_q [TARGETS][NW];
    logic [PRIO_BITS-1:0]  thr_q [TARGETS];
    logic [IDW-1:0]        best_id_q [TARGETS];
    logic [PRIO_BITS-1:0]  best_pr_q [TARGETS];
    logic [IDW-1:0]        bid_c [TARGETS];
    logic [PRIO_BITS-1:0]  bp_c [TARGETS];

    logic [NW*32-1:0]      pend;
    logic [31:0]           pend_w [NW];
    logic [31:0]           wmask [NW];
    logic [NW*32-1:0]      en_flat [TARGETS];

    assign req = wb.wb_cyc & wb.wb_stb;
    assign rd  = req & ~ack_q & ~wb.wb_we;
    assign wr  = req & ~ack_q & wb.wb_we;
    assign d   = decode(wb.wb_adr[19:0]);

    assign unused_adr = ^wb.wb_adr[PADDR_SIZE-1:20];

    assign id_ok = (d.idx != 10'd0) && ({1'b0, d.idx} < 11'(SOURCES));
    assign k_ok  = {1'b0, d.idx} < 11'(NW);
    assign t_ok  = {1'b0, d.ctx} < 10'(TARGETS);
    assign id    = d.idx[IDW-1:0];
    assign k     = d.idx[KW-1:0];
    assign t     = d.ctx[TW-1:0];

    assign wb.wb_ack   = ack_q;
    assign wb.wb_dat_o = dat_q;

    genvar gw, gj, gi, gt;
    generate
        for (gw = 0; gw < NW; gw++) begin : g_word
            assign pend_w[gw] = pend[gw*32 +: 32];
            for (gj = 0; gj < 32; gj++) begin : g_bit
                assign wmask[gw][gj] =
                    ((gw*32 + gj) < SOURCES) && ((gw*32 + gj) != 0);
            end
            for (gt = 0; gt < TARGETS; gt++) begin : g_ef
                assign en_flat[gt][gw*32 +: 32] = en_q[gt][gw];
            end
        end

        assign pend[0] = 1'b0;
        if (NW*32 > SOURCES) begin : g_pad
            assign pend[NW*32-1:SOURCES] = '0;
        end

        for (gi = 1; gi < SOURCES; gi++) begin : g_src
            logic clm;
            logic cmp;
            assign clm = ack_q & claim_q & (dat_q == PDATA_SIZE'(gi));
            assign cmp = wr && (d.rgn == RGN_CLAIM) && t_ok &&
                         (wb.wb_dat_i == PDATA_SIZE'(gi)) &&
                         en_flat[t][gi];
            plic_gateway #(
                .MODE(trig_e'(EDGE_MASK[gi]))
            ) u_gw (
                .clk      (clk),
                .reset    (reset),
                .line     (sources[gi]),
                .claim    (clm),
                .complete (cmp),
                .pending  (pend[gi])
            );
        end

        for (gt = 0; gt < TARGETS; gt++) begin : g_arb
            logic [IDW-1:0]       bid;
            logic [PRIO_BITS-1:0] bp;
            // strict compare keeps the lowest ID on a tie
            always_comb begin
                bid = '0;
                bp  = '0;
                for (int i = 1; i < SOURCES; i++) begin
                    if (pend[i] && en_flat[gt][i] && prio_q[i] > bp) begin
                        bp  = prio_q[i];
                        bid = IDW'(i);
                    end
                end
            end
            assign bid_c[gt] = bid;
            assign bp_c[gt]  = bp;
        end
    endgenerate

    always_comb begin
        rdata = '0;
        case (d.rgn)
            RGN_PRIO:  if (id_ok) rdata[PRIO_BITS-1:0] = prio_q[id];
            RGN_PEND:  if (k_ok) rdata = pend_w[k];
            RGN_EN:    if (t_ok && k_ok) rdata = en_q[t][k];
            RGN_THR:   if (t_ok) rdata[PRIO_BITS-1:0] = thr_q[t];
            RGN_CLAIM: if (t_ok) rdata[IDW-1:0] = best_id_q[t];
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            claim_q <= 1'b0;
            targets <= '0;
            for (int i = 0; i < SOURCES; i++)
                prio_q[i] <= '0;
            for (int g = 0; g < TARGETS; g++) begin
                thr_q[g]     <= '0;
                best_id_q[g] <= '0;
                best_pr_q[g] <= '0;
                for (int w = 0; w < NW; w++)
                    en_q[g][w] <= '0;
            end
        end else begin
            ack_q   <= req & ~ack_q;
            claim_q <= rd && (d.rgn == RGN_CLAIM) && t_ok;
            if (rd)
                dat_q <= rdata;
            if (wr) begin
                case (d.rgn)
                    RGN_PRIO: if (id_ok)
                        prio_q[id] <= wb.wb_dat_i[PRIO_BITS-1:0];
                    RGN_EN: if (t_ok && k_ok)
                        en_q[t][k] <= wb.wb_dat_i[31:0] & wmask[k];
                    RGN_THR: if (t_ok)
                        thr_q[t] <= wb.wb_dat_i[PRIO_BITS-1:0];
                    default: ;
                endcase
            end
            for (int g = 0; g < TARGETS; g++) begin
                best_id_q[g] <= bid_c[g];
                best_pr_q[g] <= bp_c[g];
                targets[g]   <= best_pr_q[g] > thr_q[g];
            end
        end
    end
endmodule

// File: tb/tb_wishbone_plic_gen2.sv
// Directed bench: bus tasks push expected read data, a monitor
// pops and compares on every ack; target lines are checked directly.
module tb_wishbone_plic_gen2;
    import plic_gen2_pkg::*;

    localparam logic [29:0] PEND0 = 30'h00400;
    localparam logic [29:0] EN0   = 30'h00800;
    localparam logic [29:0] THR0  = 30'h80000;
    localparam logic [29:0] CLM0  = 30'h80001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] sources = '0;
    logic [1:0]  targets;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_dat_q [$];
    bit          exp_chk_q [$];
    string       exp_nm_q  [$];
    logic        prev_ack = 1'b0;

    wishbone_plic_gen2_if #(.PADDR_SIZE(30)) bus ();

    wishbone_plic_gen2 #(
        .SOURCES    (32),
        .TARGETS    (2),
        .PRIO_BITS  (3),
        .EDGE_MASK  (32'h0000_0080),
        .PADDR_SIZE (30),
        .PDATA_SIZE (32)
    ) dut (
        .clk     (clk),
        .reset   (rst),
        .wb      (bus),
        .sources (sources),
        .targets (targets)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wb_ack) begin
            n_cmp++;
            if (prev_ack) begin
                n_fail++;
                $display("FAIL ack_width: ack high two cycles, required one");
            end
            if (exp_dat_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_ack: ack=1 with no access open");
            end else begin
                logic [31:0] e;
                bit          c;
                string       nm;
                e  = exp_dat_q.pop_front();
                c  = exp_chk_q.pop_front();
                nm = exp_nm_q.pop_front();
                if (c) begin
                    n_cmp++;
                    if (bus.wb_dat_o !== e) begin
                        n_fail++;
                        $display("FAIL %s: got %h required %h",
                                 nm, bus.wb_dat_o, e);
                    end
                end
            end
        end
        prev_ack = bus.wb_ack;
    end

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic xfer(input logic [29:0] a, input logic we,
                        input logic [31:0] wd, input bit chk,
                        input logic [31:0] exp, input string nm);
        bit got;
        exp_dat_q.push_back(exp);
        exp_chk_q.push_back(chk);
        exp_nm_q.push_back(nm);
        bus.wb_cyc   = 1'b1;
        bus.wb_stb   = 1'b1;
        bus.wb_we    = we;
        bus.wb_adr   = a;
        bus.wb_dat_i = wd;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(posedge clk);
            #1;
            if (bus.wb_ack) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: ack=0 required 1", nm);
            void'(exp_dat_q.pop_back());
            void'(exp_chk_q.pop_back());
            void'(exp_nm_q.pop_back());
        end else begin
            ticks(1);
        end
        bus.wb_cyc = 1'b0;
        bus.wb_stb = 1'b0;
        bus.wb_we  = 1'b0;
    endtask

    task automatic rd(input logic [29:0] a, input logic [31:0] exp,
                      input string nm);
        xfer(a, 1'b0, '0, 1'b1, exp, nm);
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] wd);
        xfer(a, 1'b1, wd, 1'b0, '0, "write");
    endtask

    task automatic pulse7();
        sources[7] = 1'b1;
        ticks(2);
        sources[7] = 1'b0;
        ticks(2);
    endtask

    initial begin
        bus.wb_cyc   = 1'b0;
        bus.wb_stb   = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_adr   = '0;
        bus.wb_dat_i = '0;
        ticks(3);
        check("rst_ack", {31'd0, bus.wb_ack}, 32'd0);
        check("rst_dat", bus.wb_dat_o, 32'd0);
        check("rst_targets", {30'd0, targets}, 32'd0);
        rst = 1'b1;
        ticks(1);

        // level source 3
        wr(30'd3, 32'd2);
        wr(EN0, 32'h8);
        wr(THR0, 32'd1);
        sources[3] = 1'b1;
        ticks(3);
        check("t0_level", {31'd0, targets[0]}, 32'd1);
        check("t1_idle", {31'd0, targets[1]}, 32'd0);
        rd(CLM0, 32'd3, "claim_level");
        ticks(3);
        check("t0_after_claim", {31'd0, targets[0]}, 32'd0);
        rd(PEND0, 32'd0, "pend_after_claim");
        sources[3] = 1'b0;
        wr(CLM0, 32'd3);

        // priority tie between 5 and 9
        wr(30'd5, 32'd4);
        wr(30'd9, 32'd4);
        wr(EN0, 32'h220);
        sources[5] = 1'b1;
        sources[9] = 1'b1;
        ticks(3);
        rd(CLM0, 32'd5, "claim_tie");
        sources[5] = 1'b0;
        wr(CLM0, 32'd5);
        ticks(3);
        rd(CLM0, 32'd9, "claim_next");
        sources[9] = 1'b0;
        wr(CLM0, 32'd9);
        ticks(3);
        rd(CLM0, 32'd0, "claim_empty");

        // edge source 7 with deferred edge and a dropped edge
        wr(30'd7, 32'd3);
        wr(EN0, 32'h80);
        pulse7();
        pulse7();
        pulse7();
        ticks(2);
        check("t0_edge", {31'd0, targets[0]}, 32'd1);
        rd(CLM0, 32'd7, "claim_edge1");
        wr(CLM0, 32'd7);
        ticks(3);
        rd(CLM0, 32'd7, "claim_edge2");
        wr(CLM0, 32'd7);
        ticks(3);
        rd(CLM0, 32'd0, "claim_edge3");

        // threshold masking and out-of-range complete
        wr(30'd3, 32'd7);
        wr(EN0, 32'h8);
        wr(THR0, 32'hF);
        rd(THR0, 32'd7, "thr_trunc");
        sources[3] = 1'b1;
        ticks(4);
        check("t0_masked", {31'd0, targets[0]}, 32'd0);
        wr(CLM0, 32'd40);
        wr(THR0, 32'd6);
        ticks(3);
        check("t0_unmasked", {31'd0, targets[0]}, 32'd1);

        // back-to-back reads and odd locations
        rd(30'd3, 32'd7, "prio_rd");
        rd(PEND0, 32'h8, "pend_rd");
        rd(30'h7FFFF, 32'd0, "unmapped");
        wr(30'd0, 32'd5);
        rd(30'd0, 32'd0, "prio_id0");
        wr(30'd10, 32'hFD);
        rd(30'd10, 32'd5, "prio_trunc");
        rd(30'h00401, 32'd0, "pend_word1");
        wr(EN0, 32'hFFFF_FFFF);
        rd(EN0, 32'hFFFF_FFFE, "en_id0");
        wr(EN0, 32'h8);

        // level line still high re-pends after complete
        rd(CLM0, 32'd3, "claim_hi");
        wr(CLM0, 32'd3);
        ticks(2);
        rd(PEND0, 32'h8, "repend");

        // reset during an open claim
        bus.wb_cyc = 1'b1;
        bus.wb_stb = 1'b1;
        bus.wb_we  = 1'b0;
        bus.wb_adr = CLM0;
        rst = 1'b0;
        ticks(3);
        check("rst_mid_ack", {31'd0, bus.wb_ack}, 32'd0);
        check("rst_mid_dat", bus.wb_dat_o, 32'd0);
        check("rst_mid_targets", {30'd0, targets}, 32'd0);
        bus.wb_cyc = 1'b0;
        bus.wb_stb = 1'b0;
        rst = 1'b1;
        ticks(2);
        rd(30'd3, 32'd0, "rst_prio");
        rd(EN0, 32'd0, "rst_en");
        rd(THR0, 32'd0, "rst_thr");
        rd(CLM0, 32'd0, "rst_claim");
        ticks(2);

        n_cmp++;
        if (exp_dat_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d accesses without ack, required 0",
                     exp_dat_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
